// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the staged reset-release sequencer.
package reset_seq_pkg;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEQ  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    localparam int DEF_NUM_STAGES = 5;
    localparam int DEF_CNT_W      = 32;
    localparam int DEF_DWELL      = 100;
    localparam int DEF_AUTO_START = 1;

    // Width needed to count 0..n stages inclusive.
    function automatic int idx_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the top-level controller and the sequencer.
// Handshake: start and restart are single-cycle request pulses sampled on
// the rising clock edge (no ready; they are always accepted or ignored
// according to state), dwell_we writes dwell_data on the edge it is high,
// and stage_adv is a one-cycle pulse in the cycle the stage count rises.
interface reset_sequencer_if
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int CNT_W      = DEF_CNT_W
);
    localparam int IDX_W = idx_width(NUM_STAGES);

    logic                  start;
    logic                  pause;
    logic                  restart;
    logic                  dwell_we;
    logic [IDX_W-1:0]      dwell_idx;
    logic [CNT_W-1:0]      dwell_data;
    logic [NUM_STAGES-1:0] stage_hold;
    logic [IDX_W-1:0]      stage;
    logic                  stage_adv;
    logic                  busy;
    logic                  done;
    seq_state_e            state;       // debug view of the FSM state

    modport master (
        output start, pause, restart, dwell_we, dwell_idx, dwell_data,
        input  stage_hold, stage, stage_adv, busy, done, state
    );

    modport slave (
        input  start, pause, restart, dwell_we, dwell_idx, dwell_data,
        output stage_hold, stage, stage_adv, busy, done, state
    );

endinterface

// File: rtl/reset_sequencer_dwell_timer.sv
// Dwell counter: cleared on request, held while frozen, otherwise counts up.
// Expire flags when the count has reached the supplied limit.
module seq_dwell_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_freeze,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_expire
);
    logic [CNT_W-1:0] r_cnt;

    // Counter register: clear wins over freeze; never counts past the limit
    // because the owner clears it on expiry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (!i_freeze) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expire = (r_cnt >= i_limit);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset-release sequencer: releases NUM_STAGES hold lines one at a
// time, each after a programmable dwell, with start/pause/restart control.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES    = DEF_NUM_STAGES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int DEFAULT_DWELL = DEF_DWELL,
    parameter int AUTO_START    = DEF_AUTO_START
) (
    input  logic             clk,
    input  logic             rst,
    reset_sequencer_if.slave bus
);
    localparam int               IDX_W       = idx_width(NUM_STAGES);
    localparam logic [IDX_W-1:0] LAST        = IDX_W'(NUM_STAGES);
    localparam seq_state_e       RESET_STATE = (AUTO_START != 0) ? SEQ : IDLE;

    logic [CNT_W-1:0]      r_dwell [NUM_STAGES];
    seq_state_e            r_state;
    seq_state_e            w_state_n;
    logic [IDX_W-1:0]      r_stage;
    logic [IDX_W-1:0]      w_stage_n;
    logic [NUM_STAGES-1:0] r_hold;
    logic [NUM_STAGES-1:0] w_hold_n;
    logic                  r_adv;
    logic                  w_adv_n;
    logic                  r_busy;
    logic                  r_done;
    logic [CNT_W-1:0]      w_limit;
    logic                  w_expire;
    logic                  w_clear;
    logic                  w_run;
    logic                  w_freeze;

    // Dwell register file; out-of-range indices are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                r_dwell[k] <= CNT_W'(DEFAULT_DWELL);
            end
        end else if (bus.dwell_we && (bus.dwell_idx < LAST)) begin
            r_dwell[bus.dwell_idx] <= bus.dwell_data;
        end
    end

    // Live dwell of the current stage; the compare sees writes one edge later.
    always_comb begin
        w_limit = '0;
        if (r_stage < LAST) begin
            w_limit = r_dwell[r_stage];
        end
    end

    assign w_freeze = !w_run;

    seq_dwell_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_freeze (w_freeze),
        .i_limit  (w_limit),
        .o_expire (w_expire)
    );

    // Next state and outputs; priority restart > start > pause > count.
    always_comb begin
        w_state_n = r_state;
        w_stage_n = r_stage;
        w_adv_n   = 1'b0;
        w_clear   = 1'b0;
        w_run     = 1'b0;
        w_hold_n  = '1;
        if (bus.restart) begin
            w_state_n = SEQ;
            w_stage_n = '0;
            w_clear   = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        w_state_n = SEQ;
                        w_stage_n = '0;
                        w_clear   = 1'b1;
                    end
                end
                SEQ: begin
                    if (!bus.pause) begin
                        if (w_expire) begin
                            w_stage_n = r_stage + IDX_W'(1);
                            w_adv_n   = 1'b1;
                            w_clear   = 1'b1;
                            if (w_stage_n == LAST) begin
                                w_state_n = DONE;
                            end
                        end else begin
                            w_run = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_hold_n[i] = (IDX_W'(i) >= w_stage_n);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RESET_STATE;
            r_stage <= '0;
            r_hold  <= '1;
            r_adv   <= 1'b0;
            r_busy  <= (AUTO_START != 0);
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_stage <= w_stage_n;
            r_hold  <= w_hold_n;
            r_adv   <= w_adv_n;
            r_busy  <= (w_state_n == SEQ);
            r_done  <= (w_state_n == DONE);
        end
    end

    assign bus.stage_hold = r_hold;
    assign bus.stage      = r_stage;
    assign bus.stage_adv  = r_adv;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: one auto-start instance (A) and one
// manual-start instance (B) sharing clock and reset.
module tb_reset_sequencer;
    import reset_seq_pkg::*;

    localparam int NS = 5;
    localparam int CW = 32;

    typedef struct {
        logic        start;
        logic        pause;
        logic        restart;
        logic        we;
        logic [2:0]  idx;
        logic [31:0] data;
        int          exp_stage;
        logic        exp_adv;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    vec_t vq[$];
    int   dm [NS];

    always #5 clk = ~clk;

    reset_sequencer_if #(.NUM_STAGES(NS), .CNT_W(CW)) ifa ();
    reset_sequencer_if #(.NUM_STAGES(NS), .CNT_W(CW)) ifb ();

    reset_sequencer #(.NUM_STAGES(NS), .CNT_W(CW), .DEFAULT_DWELL(100), .AUTO_START(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    reset_sequencer #(.NUM_STAGES(NS), .CNT_W(CW), .DEFAULT_DWELL(100), .AUTO_START(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    // ---------------- clock/reset helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Hold bit i stays set while i >= released-stage count.
    function automatic logic [NS-1:0] hold_of(input int j);
        logic [NS-1:0] h;
        for (int i = 0; i < NS; i++) h[i] = (i >= j);
        return h;
    endfunction

    task automatic chk_a(input string tag, input int j, input logic adv);
        chk({tag, ".stage"}, 32'(ifa.stage), 32'(j));
        chk({tag, ".hold"}, 32'(ifa.stage_hold), 32'(hold_of(j)));
        chk({tag, ".adv"}, 32'(ifa.stage_adv), 32'(adv));
        chk({tag, ".busy"}, 32'(ifa.busy), 32'(j < NS));
        chk({tag, ".done"}, 32'(ifa.done), 32'(j == NS));
    endtask

    task automatic chk_b_idle(input string tag);
        chk({tag, ".hold"}, 32'(ifb.stage_hold), 32'h1f);
        chk({tag, ".busy"}, 32'(ifb.busy), 32'h0);
        chk({tag, ".done"}, 32'(ifb.done), 32'h0);
    endtask

    // ---------------- drivers ----------------
    task automatic wr_a(input logic [2:0] idx, input logic [31:0] data);
        ifa.dwell_we   = 1'b1;
        ifa.dwell_idx  = idx;
        ifa.dwell_data = data;
        step();
        ifa.dwell_we   = 1'b0;
    endtask

    task automatic restart_a();
        ifa.restart = 1'b1;
        step();
        ifa.restart = 1'b0;
    endtask

    function automatic void add(input logic s, input logic p, input logic r, input logic we,
                                input logic [2:0] idx, input logic [31:0] d,
                                input int st, input logic adv);
        vec_t v;
        v.start = s; v.pause = p; v.restart = r; v.we = we;
        v.idx = idx; v.data = d; v.exp_stage = st; v.exp_adv = adv;
        vq.push_back(v);
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: time limit expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- test body ----------------
    initial begin
        int exp_seq [18];
        int prev;
        int n;
        int j;
        int sum;
        int adv_cnt;
        logic p;

        ifa.start = 0; ifa.pause = 0; ifa.restart = 0; ifa.dwell_we = 0;
        ifa.dwell_idx = '0; ifa.dwell_data = '0;
        ifb.start = 0; ifb.pause = 0; ifb.restart = 0; ifb.dwell_we = 0;
        ifb.dwell_idx = '0; ifb.dwell_data = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_a("reset_a", 0, 1'b0);
        chk_b_idle("reset_b");
        rst = 1'b1;

        // Default timing: release every 101 edges; B waits idle meanwhile.
        for (int e = 1; e <= 505; e++) begin
            step();
            chk_a($sformatf("auto_e%0d", e), e / 101, (e % 101) == 0);
            chk_b_idle("idle_b");
        end
        for (int e = 0; e < 2000; e++) begin
            step();
            chk("done_hold.done", 32'(ifa.done), 32'h1);
            chk("done_hold.hold", 32'(ifa.stage_hold), 32'h0);
        end

        // Manual start on B: busy next edge, first release 101 edges later.
        ifb.start = 1'b1;
        step();
        ifb.start = 1'b0;
        chk("start_b.busy", 32'(ifb.busy), 32'h1);
        chk("start_b.stage", 32'(ifb.stage), 32'h0);
        for (int e = 1; e <= 101; e++) begin
            step();
            chk($sformatf("start_b_e%0d.hold", e), 32'(ifb.stage_hold), (e == 101) ? 32'h1e : 32'h1f);
        end

        // Vector table: writes in DONE (incl. ignored idx 7), ignored start/pause,
        // restart+pause, then stage lengths 1,4,1,10,2.
        exp_seq = '{1, 1, 1, 1, 2, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 4, 4, 5};
        add(0, 0, 0, 1, 3'd0, 32'd0, 5, 0);
        add(0, 0, 0, 1, 3'd1, 32'd3, 5, 0);
        add(0, 0, 0, 1, 3'd2, 32'd0, 5, 0);
        add(0, 0, 0, 1, 3'd3, 32'd9, 5, 0);
        add(0, 0, 0, 1, 3'd4, 32'd1, 5, 0);
        add(0, 0, 0, 1, 3'd7, 32'd0, 5, 0);
        add(1, 1, 0, 0, 3'd0, 32'd0, 5, 0);
        add(0, 1, 1, 0, 3'd0, 32'd0, 0, 0);
        prev = 0;
        for (int k = 0; k < 18; k++) begin
            add(0, 0, 0, 0, 3'd0, 32'd0, exp_seq[k], exp_seq[k] != prev);
            prev = exp_seq[k];
        end
        add(0, 1, 0, 0, 3'd0, 32'd0, 5, 0);
        adv_cnt = 0;
        for (int i = 0; i < vq.size(); i++) begin
            ifa.start = vq[i].start; ifa.pause = vq[i].pause; ifa.restart = vq[i].restart;
            ifa.dwell_we = vq[i].we; ifa.dwell_idx = vq[i].idx; ifa.dwell_data = vq[i].data;
            step();
            if (ifa.stage_adv === 1'b1) adv_cnt++;
            chk_a($sformatf("vec%0d", i), vq[i].exp_stage, vq[i].exp_adv);
        end
        ifa.start = 0; ifa.pause = 0; ifa.restart = 0; ifa.dwell_we = 0;
        chk("vec.adv_count", 32'(adv_cnt), 32'd5);

        // Pause 50 cycles inside stage 2: stage 2 lasts 151 cycles.
        for (int k = 0; k < NS; k++) wr_a(3'(k), 32'd100);
        restart_a();
        chk_a("p_restart", 0, 1'b0);
        repeat (202) step();
        chk_a("p_e202", 2, 1'b1);
        repeat (30) step();
        ifa.pause = 1'b1;
        for (int e = 0; e < 50; e++) begin
            step();
            chk_a("paused", 2, 1'b0);
        end
        ifa.pause = 1'b0;
        repeat (70) step();
        chk_a("p_e352", 2, 1'b0);
        step();
        chk_a("p_e353", 3, 1'b1);

        // Restart together with pause mid-stage 3; dwells survive the restart.
        repeat (10) step();
        ifa.pause = 1'b1;
        restart_a();
        ifa.pause = 1'b0;
        chk_a("rs3", 0, 1'b0);
        repeat (100) step();
        chk_a("rs3_e100", 0, 1'b0);
        step();
        chk_a("rs3_e101", 1, 1'b1);

        // Lower current dwell below counter (40) -> advance on the next edge.
        restart_a();
        repeat (40) step();
        wr_a(3'd0, 32'd5);
        chk_a("live_wr", 0, 1'b0);
        step();
        chk_a("live_adv", 1, 1'b1);

        // Write in the advancing cycle: decision uses old dwell (5).
        restart_a();
        repeat (5) step();
        wr_a(3'd0, 32'd200);
        chk_a("same_cyc", 1, 1'b1);
        restart_a();
        repeat (200) step();
        chk_a("new200_e200", 0, 1'b0);
        step();
        chk_a("new200_e201", 1, 1'b1);

        // Asynchronous reset between edges; dwell[0] returns to 100.
        repeat (3) step();
        #2;
        rst = 1'b0;
        #1;
        chk_a("async", 0, 1'b0);
        chk_b_idle("async_b");
        step();
        chk_a("async_hold", 0, 1'b0);
        rst = 1'b1;
        repeat (100) step();
        chk_a("postrst_e100", 0, 1'b0);
        step();
        chk_a("postrst_e101", 1, 1'b1);
        chk_b_idle("postrst_b");

        // Random dwells and pause pattern vs cumulative-sum reference.
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < NS; k++) begin
                dm[k] = $urandom_range(0, 7);
                wr_a(3'(k), 32'(dm[k]));
            end
            restart_a();
            chk_a("rnd_restart", 0, 1'b0);
            n = 0;
            prev = 0;
            for (int c = 0; c < 80; c++) begin
                p = ($urandom_range(0, 3) == 0);
                ifa.pause = p;
                step();
                if (!p) n++;
                j = 0;
                sum = 0;
                for (int k = 0; k < NS; k++) begin
                    sum += dm[k] + 1;
                    if (sum <= n) j++;
                end
                chk_a($sformatf("rnd%0d_c%0d", it, c), j, j != prev);
                prev = j;
            end
            ifa.pause = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
